fetch_unit: RTL

- Instruction fetch stage of the RV32 core; the fetch PC register sits directly downstream of the next-PC 2:1 mux.
- The mux output (branch/jump target) arrives as a redirect; otherwise the PC advances by 4.
- Issues requests to instruction memory over a valid/ready handshake and tracks in-order responses.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready handshake and flushes stale work on redirect.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: issues in-order memory requests under a credit limit,
// buffers responses with their PCs, and flushes stale work on a next-PC redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_pc_d   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_inst_d [DEPTH];

  logic req_fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit: outstanding requests plus buffered instructions never exceed the FIFO depth
  always_comb begin
    imem_req_valid = !rst && !redirect_valid &&
                     ((32'(inflight_q) + 32'(count_q)) < 32'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    inst_valid     = !rst && (count_q != '0);
    inst_data      = inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
    inst_pc        = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    req_fire       = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && !redirect_valid && (discard_q == '0);
    pop            = inst_valid && inst_ready;
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path and must be dropped
      fetch_pc_d = redirect_pc & ~32'h3;
      rsp_pc_d   = redirect_pc & ~32'h3;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = inflight_q - CW'(imem_rsp_valid);
      discard_d  = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
        fifo_inst_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
        rsp_pc_d              = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q marks them valid
  always_ff @(posedge clk) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_inst_q <= fifo_inst_d;
  end

endmodule
